cache_trace_player: RTL and testbench

Plays an address trace into the set-associative cache and tallies the hit/miss result of every access. It is the initiator-side counterpart to the trace data package: it walks trace entries 0..TRACE_DEPTH-1, issues each address as a cache read request with a valid/ready handshake, waits for the cache's hit/miss response, and keeps the running hit and miss counts. It sits between the trace memory (QSORT/MM16/MM32/LU data) and the cache request port in the simulation top.

---
 rtl/cache_trace_player.sv | 103 ++++++++++
 tb/tb_cache_trace_player.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_trace_player.sv
// Replays an address trace into the cache, one outstanding read at a time,
// and keeps saturating hit/miss tallies for the current or most recent run.
module cache_trace_player #(
  parameter int TRACE_DEPTH = 256,
  parameter int ADDR_WIDTH  = 32,
  parameter int CNT_WIDTH   = 32,
  parameter int IDX_WIDTH   = $clog2(TRACE_DEPTH+1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic [IDX_WIDTH-1:0]  trace_idx,
  input  logic [ADDR_WIDTH-1:0] trace_addr,
  output logic                  req_valid,
  output logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  req_ready,
  input  logic                  resp_valid,
  input  logic                  resp_hit,
  output logic [CNT_WIDTH-1:0]  hit_count,
  output logic [CNT_WIDTH-1:0]  miss_count,
  output logic                  busy,
  output logic                  done,
  output logic                  proto_err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [IDX_WIDTH-1:0] LAST_IDX =
    IDX_WIDTH'(TRACE_DEPTH-1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [1:0]           r_state;
  logic [IDX_WIDTH-1:0] r_idx;
  logic [CNT_WIDTH-1:0] r_hit;
  logic [CNT_WIDTH-1:0] r_miss;
  logic                 r_perr;

  logic w_issue;
  logic w_wait;

  assign w_issue    = (r_state == S_ISSUE);
  assign w_wait     = (r_state == S_WAIT);

  assign trace_idx  = r_idx;
  assign req_valid  = w_issue;
  assign req_addr   = trace_addr;
  assign hit_count  = r_hit;
  assign miss_count = r_miss;
  assign busy       = w_issue | w_wait;
  assign done       = (r_state == S_DONE);
  assign proto_err  = r_perr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_hit   <= '0;
      r_miss  <= '0;
      r_perr  <= 1'b0;
    end else begin
      // a response is only legal while a request is outstanding
      if (resp_valid && !w_wait)
        r_perr <= 1'b1;
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state <= S_ISSUE;
            r_idx   <= '0;
            r_hit   <= '0;
            r_miss  <= '0;
            r_perr  <= 1'b0;
          end
        end
        S_ISSUE: begin
          if (req_ready)
            r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (resp_valid) begin
            if (resp_hit) begin
              if (r_hit != CNT_MAX)
                r_hit <= r_hit + CNT_WIDTH'(1);
            end else begin
              if (r_miss != CNT_MAX)
                r_miss <= r_miss + CNT_WIDTH'(1);
            end
            if (r_idx == LAST_IDX) begin
              r_state <= S_DONE;
            end else begin
              r_idx   <= r_idx + IDX_WIDTH'(1);
              r_state <= S_ISSUE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_trace_player.sv
// Scoreboarded bench for cache_trace_player: a 4-entry trace instance
// and a 5-entry instance with 2-bit counters for saturation.
module tb_cache_trace_player;

  localparam int AW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          a_start = 1'b0;
  logic          a_req_ready = 1'b0;
  logic          a_resp_valid = 1'b0;
  logic          a_resp_hit = 1'b0;
  logic [2:0]    a_idx;
  logic [AW-1:0] a_trace_addr;
  logic [AW-1:0] a_req_addr;
  logic          a_req_valid;
  logic          a_busy;
  logic          a_done;
  logic          a_perr;
  logic [31:0]   a_hit;
  logic [31:0]   a_miss;

  logic [AW-1:0] trace_a [4] = '{32'h00, 32'h40, 32'h00, 32'h80};
  assign a_trace_addr = (a_idx < 3'd4) ? trace_a[a_idx[1:0]] : 32'hDEAD_BEEF;

  cache_trace_player #(
    .TRACE_DEPTH(4),
    .ADDR_WIDTH (AW),
    .CNT_WIDTH  (32)
  ) u_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (a_start),
    .trace_idx (a_idx),
    .trace_addr(a_trace_addr),
    .req_valid (a_req_valid),
    .req_addr  (a_req_addr),
    .req_ready (a_req_ready),
    .resp_valid(a_resp_valid),
    .resp_hit  (a_resp_hit),
    .hit_count (a_hit),
    .miss_count(a_miss),
    .busy      (a_busy),
    .done      (a_done),
    .proto_err (a_perr)
  );

  logic          b_start = 1'b0;
  logic          b_req_ready = 1'b1;
  logic          b_resp_valid = 1'b0;
  logic          b_resp_hit = 1'b0;
  logic [2:0]    b_idx;
  logic [AW-1:0] b_trace_addr;
  logic [AW-1:0] b_req_addr;
  logic          b_req_valid;
  logic          b_busy;
  logic          b_done;
  logic          b_perr;
  logic [1:0]    b_hit;
  logic [1:0]    b_miss;

  assign b_trace_addr = {25'd0, b_idx, 4'd0};

  cache_trace_player #(
    .TRACE_DEPTH(5),
    .ADDR_WIDTH (AW),
    .CNT_WIDTH  (2)
  ) u_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (b_start),
    .trace_idx (b_idx),
    .trace_addr(b_trace_addr),
    .req_valid (b_req_valid),
    .req_addr  (b_req_addr),
    .req_ready (b_req_ready),
    .resp_valid(b_resp_valid),
    .resp_hit  (b_resp_hit),
    .hit_count (b_hit),
    .miss_count(b_miss),
    .busy      (b_busy),
    .done      (b_done),
    .proto_err (b_perr)
  );

  int n_checks = 0;
  int n_fail = 0;

  logic [AW-1:0] exp_addr_q[$];
  logic [63:0]   exp_cnt_q[$];

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: accepted requests and run completions against the queues
  logic a_done_q = 1'b0;
  always @(negedge clk) begin
    logic [AW-1:0] ea;
    logic [63:0]   ec;
    if (rst_n && a_req_valid && a_req_ready) begin
      n_checks++;
      if (exp_addr_q.size() == 0) begin
        n_fail++;
        $display("FAIL accept_extra: got addr %0h, expected no request",
                 a_req_addr);
      end else begin
        ea = exp_addr_q.pop_front();
        if (a_req_addr !== ea) begin
          n_fail++;
          $display("FAIL accept_addr: got %0h, expected %0h",
                   a_req_addr, ea);
        end
      end
    end
    if (rst_n && a_done && !a_done_q) begin
      n_checks++;
      if (exp_cnt_q.size() == 0) begin
        n_fail++;
        $display("FAIL done_extra: got done with hit=%0d miss=%0d, expected none",
                 a_hit, a_miss);
      end else begin
        ec = exp_cnt_q.pop_front();
        if ({a_hit, a_miss} !== ec) begin
          n_fail++;
          $display("FAIL done_counts: got hit=%0d miss=%0d, expected hit=%0d miss=%0d",
                   a_hit, a_miss, ec[63:32], ec[31:0]);
        end
      end
    end
    a_done_q = a_done;
  end

  task automatic run_a(input logic [3:0] hits, input int dly,
                       input int stall_e, input int stall_n,
                       input bit spam, input int abort_e);
    int h;
    int m;
    h = 0;
    m = 0;
    for (int e = 0; e < 4; e++) begin
      exp_addr_q.push_back(trace_a[e]);
      if (hits[e]) h++;
      else m++;
    end
    if (abort_e < 0)
      exp_cnt_q.push_back({32'(h), 32'(m)});
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    check("busy_after_start", a_busy, 1);
    check("cnt_cleared", {a_hit, a_miss}, 0);
    for (int e = 0; e < 4; e++) begin
      check("req_valid_issue", a_req_valid, 1);
      check("idx_issue", a_idx, e);
      if (e == stall_e) begin
        for (int s = 0; s < stall_n; s++) begin
          check("stall_valid", a_req_valid, 1);
          check("stall_addr", a_req_addr, trace_a[e]);
          tick();
        end
      end
      a_req_ready = 1'b1;
      a_start = spam;
      tick();
      a_req_ready = 1'b0;
      a_start = 1'b0;
      check("req_valid_wait", a_req_valid, 0);
      if (e == abort_e) begin
        #2 rst_n = 1'b0;
        #1;
        check("rst_req_valid", a_req_valid, 0);
        check("rst_busy", a_busy, 0);
        check("rst_done", a_done, 0);
        check("rst_counts", {a_hit, a_miss}, 0);
        check("rst_idx", a_idx, 0);
        check("rst_perr", a_perr, 0);
        exp_addr_q.delete();
        tick();
        rst_n = 1'b1;
        tick();
        a_resp_valid = 1'b1;
        a_resp_hit = 1'b1;
        tick();
        a_resp_valid = 1'b0;
        check("stray_resp_perr", a_perr, 1);
        check("stray_resp_counts", {a_hit, a_miss}, 0);
        check("stray_resp_busy", a_busy, 0);
        return;
      end
      for (int d = 1; d < dly; d++) begin
        tick();
        check("no_req_in_wait", a_req_valid, 0);
      end
      if (e == 3) check("done_not_early", a_done, 0);
      a_resp_valid = 1'b1;
      a_resp_hit = hits[e];
      a_start = spam;
      tick();
      a_resp_valid = 1'b0;
      a_start = 1'b0;
      check("running_total", a_hit + a_miss, e + 1);
    end
    check("done_after_last", a_done, 1);
    check("busy_at_done", a_busy, 0);
    check("req_valid_done", a_req_valid, 0);
    check("perr_clean", a_perr, 0);
  endtask

  initial begin
    #12;
    check("reset_idx", a_idx, 0);
    check("reset_req_valid", a_req_valid, 0);
    check("reset_busy_done", {a_busy, a_done}, 0);
    check("reset_counts", {a_hit, a_miss}, 0);
    check("reset_perr", a_perr, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // zero-wait cache, hits {0,0,1,0}
    run_a(4'b0100, 1, -1, 0, 1'b0, -1);
    // req_ready low 5 cycles on entry 1
    run_a(4'b0100, 1, 1, 5, 1'b0, -1);
    // 3-cycle response latency
    run_a(4'b1101, 3, -1, 0, 1'b0, -1);
    // restart from DONE, all hits, start spammed mid-run
    run_a(4'b1111, 1, -1, 0, 1'b1, -1);
    // reset during WAIT of entry 2
    run_a(4'b0000, 2, -1, 0, 1'b0, 2);

    // 2-bit counters, 5 entries, all misses
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    for (int e = 0; e < 5; e++) begin
      check("b_req_valid", b_req_valid, 1);
      check("b_req_addr", b_req_addr, e * 16);
      tick();
      b_resp_valid = 1'b1;
      b_resp_hit = 1'b0;
      tick();
      b_resp_valid = 1'b0;
    end
    check("b_miss_sat", b_miss, 3);
    check("b_hit", b_hit, 0);
    check("b_done", b_done, 1);
    check("b_idx_last", b_idx, 4);
    check("b_perr", b_perr, 0);

    check("addr_q_drained", exp_addr_q.size(), 0);
    check("cnt_q_drained", exp_cnt_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
